// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch buffer entry type for the instruction fetch unit.
package fetch_pkg;

    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
    localparam logic [31:0] INSN_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        pred;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: small circular FIFO of fetch entries with a synchronous flush.
// Pointers wrap at DEPTH, which need not be a power of two.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch PC, redirect handling and prefetch buffer.
// Define FETCH_BRANCH_PREDICT_EN to predict backward conditional branches as taken.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] to_imem,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] fr_imem,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_pred_taken
);

    // Handshakes: an imem transfer happens on imem_req & imem_ack (to_imem holds
    // until then); the core consumes the head on inst_valid & inst_ready, and
    // inst_valid never depends on inst_ready.
    logic [31:0]  fetch_pc;
    logic [31:0]  next_pc;
    logic         next_pred;
    logic         accept;
    logic         pop;
    logic         buf_empty;
    logic         buf_full;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic [1:0]   unused_redirect_lo;

    assign unused_redirect_lo = redirect_pc[1:0];

    assign imem_req   = !rst && !buf_full;
    assign to_imem    = rst ? RESET_PC : fetch_pc;
    assign accept     = imem_req && imem_ack && !redirect_valid;
    assign inst_valid = !rst && !buf_empty;
    assign pop        = inst_valid && inst_ready;

`ifdef FETCH_BRANCH_PREDICT_EN
    logic [12:0] b_imm;

    always_comb begin
        b_imm     = {fr_imem[31], fr_imem[7], fr_imem[30:25], fr_imem[11:8], 1'b0};
        next_pred = (fr_imem[6:0] == OPC_BRANCH) && fr_imem[31];
        next_pc   = next_pred ? fetch_pc + {{19{b_imm[12]}}, b_imm}
                              : fetch_pc + 32'd4;
    end

    assign inst_pred_taken = !rst && head.pred;
`else
    logic unused_head_pred;

    always_comb begin
        next_pred = 1'b0;
        next_pc   = fetch_pc + 32'd4;
    end

    assign unused_head_pred = head.pred;
    assign inst_pred_taken  = 1'b0;
`endif

    // A redirect discards any ack in the same cycle and realigns the target.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (imem_req && imem_ack) begin
            fetch_pc <= next_pc;
        end
    end

    assign push_entry = '{pc: fetch_pc, insn: fr_imem, pred: next_pred};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (buf_empty),
        .full       (buf_full)
    );

    assign inst    = rst ? 32'h0 : head.insn;
    assign inst_pc = rst ? 32'h0 : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based reference model.
// Honours FETCH_BRANCH_PREDICT_EN the same way the design does.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BRANCH_PREDICT_EN
    localparam bit PREDICT_EN = 1'b1;
`else
    localparam bit PREDICT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] to_imem;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] fr_imem = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_pred_taken;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .to_imem         (to_imem),
        .imem_req        (imem_req),
        .imem_ack        (imem_ack),
        .fr_imem         (fr_imem),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_pred_taken (inst_pred_taken)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_insn_q[$];
    logic        exp_pred_q[$];

    function automatic int b_imm(input logic [31:0] w);
        return (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    endfunction

    function automatic logic pred_of(input logic [31:0] w);
        return PREDICT_EN && (w[6:0] == 7'b1100011) && (b_imm(w) < 0);
    endfunction

    function automatic logic [31:0] next_of(input logic [31:0] pc, input logic [31:0] w);
        return pred_of(w) ? pc + 32'(b_imm(w)) : pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= RESET_PC;
            exp_pc_q.delete(); exp_insn_q.delete(); exp_pred_q.delete();
        end else if (redirect_valid) begin
            m_pc <= redirect_pc & 32'hFFFF_FFFC;
            exp_pc_q.delete(); exp_insn_q.delete(); exp_pred_q.delete();
        end else if (imem_ack && exp_pc_q.size() < DEPTH) begin
            if (exp_pc_q.size() > 0 && inst_ready) begin
                exp_pc_q.delete(0); exp_insn_q.delete(0); exp_pred_q.delete(0);
            end
            exp_pc_q.push_back(m_pc);
            exp_insn_q.push_back(fr_imem);
            exp_pred_q.push_back(pred_of(fr_imem));
            m_pc <= next_of(m_pc, fr_imem);
        end else if (exp_pc_q.size() > 0 && inst_ready) begin
            exp_pc_q.delete(0); exp_insn_q.delete(0); exp_pred_q.delete(0);
        end
    end

    // {imem_req, to_imem, inst_valid, inst_pc, inst, inst_pred_taken}
    function automatic logic [98:0] exp_bus();
        logic not_full;
        not_full = (exp_pc_q.size() < DEPTH);
        if (rst) return {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0};
        if (exp_pc_q.size() == 0) return {1'b1, m_pc, 1'b0, 65'h0};
        return {not_full, m_pc, 1'b1, exp_pc_q[0], exp_insn_q[0], exp_pred_q[0]};
    endfunction

    function automatic logic [98:0] obs_bus();
        if (!rst && exp_pc_q.size() == 0) return {imem_req, to_imem, inst_valid, 65'h0};
        return {imem_req, to_imem, inst_valid, inst_pc, inst, inst_pred_taken};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; imem_ack = 1'b1; inst_ready = 1'b1;
        fr_imem = $urandom();
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
                inst_pred_taken !== 1'b0 || to_imem !== RESET_PC) begin
                failures++;
                $display("FAIL reset_outputs k=%0d got req=%b valid=%b inst=%h pc=%h pred=%b to=%h want all zero, to=%h",
                         k, imem_req, inst_valid, inst, inst_pc, inst_pred_taken, to_imem, RESET_PC);
            end
            tick();
        end
        rst = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || to_imem !== RESET_PC || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_req got req=%b to=%h valid=%b want req=1 to=%h valid=0",
                     imem_req, to_imem, inst_valid, RESET_PC);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] w [4];
        do_reset();
        imem_ack = 1'b1; inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w[k] = ($urandom() & 32'hFFFF_FF80) | NOP;
            fr_imem = w[k];
            @(negedge clk);
            checks++;
            if (to_imem !== 32'(4 * k)) begin
                failures++;
                $display("FAIL stream_to_imem k=%0d got=%h want=%h", k, to_imem, 32'(4 * k));
            end
            checks++;
            if (k == 0 && inst_valid !== 1'b0) begin
                failures++;
                $display("FAIL stream_first_valid got=%b want=0", inst_valid);
            end else if (k > 0 && (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (k - 1)) || inst !== w[k-1])) begin
                failures++;
                $display("FAIL stream_head k=%0d got valid=%b pc=%h inst=%h want valid=1 pc=%h inst=%h",
                         k, inst_valid, inst_pc, inst, 32'(4 * (k - 1)), w[k-1]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic        exp_req [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_to  [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            inst_ready = (k >= 4);
            fr_imem = NOP;
            @(negedge clk);
            checks++;
            if (imem_req !== exp_req[k] || to_imem !== exp_to[k]) begin
                failures++;
                $display("FAIL backpressure k=%0d got req=%b to=%h want req=%b to=%h",
                         k, imem_req, to_imem, exp_req[k], exp_to[k]);
            end
            checks++;
            if (obs_bus() !== exp_bus()) begin
                failures++;
                $display("FAIL backpressure_bus k=%0d got=%h want=%h", k, obs_bus(), exp_bus());
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_ack = 1'b1; inst_ready = 1'b0; fr_imem = NOP;
        repeat (2) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h103; fr_imem = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL redirect_full_req got=%b want=0", imem_req);
        end
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b1; fr_imem = NOP;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || to_imem !== 32'h100) begin
            failures++;
            $display("FAIL redirect_full_next got valid=%b to=%h want valid=0 to=00000100", inst_valid, to_imem);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if ((inst_valid === 1'b1 && inst === 32'hDEAD_BEEF) || obs_bus() !== exp_bus()) begin
                failures++;
                $display("FAIL redirect_after k=%0d got=%h want=%h", k, obs_bus(), exp_bus());
            end
        end
        tick();
        // Redirect while a request is being acked with buffer room.
        do_reset();
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103; fr_imem = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL redirect_open_req got=%b want=1", imem_req);
        end
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b0 || to_imem !== 32'h100) begin
                failures++;
                $display("FAIL redirect_open_next k=%0d got valid=%b to=%h want valid=0 to=00000100",
                         k, inst_valid, to_imem);
            end
            tick();
        end
    endtask

    task automatic test_predict();
        logic [31:0] exp_next;
        exp_next = PREDICT_EN ? 32'h38 : 32'h44;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1; fr_imem = 32'hFE31_1CE3;
        @(negedge clk);
        checks++;
        if (to_imem !== 32'h40) begin
            failures++;
            $display("FAIL predict_start got=%h want=00000040", to_imem);
        end
        tick();
        fr_imem = 32'h0031_1263;
        @(negedge clk);
        checks++;
        if (to_imem !== exp_next || inst_pc !== 32'h40 || inst !== 32'hFE31_1CE3 ||
            inst_pred_taken !== PREDICT_EN) begin
            failures++;
            $display("FAIL predict_backward got to=%h pc=%h inst=%h pred=%b want to=%h pc=00000040 inst=fe311ce3 pred=%b",
                     to_imem, inst_pc, inst, inst_pred_taken, exp_next, PREDICT_EN);
        end
        tick();
        imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (to_imem !== exp_next + 32'd4 || inst_pc !== exp_next || inst_pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL predict_forward got to=%h pc=%h pred=%b want to=%h pc=%h pred=0",
                     to_imem, inst_pc, inst_pred_taken, exp_next + 32'd4, exp_next);
        end
        tick();
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b1; inst_ready = 1'b0; fr_imem = NOP;
        @(negedge clk);
        checks++;
        if (to_imem !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_start got=%h want=fffffffc", to_imem);
        end
        tick();
        @(negedge clk);
        checks++;
        if (to_imem !== 32'h0 || inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_next got to=%h valid=%b pc=%h want to=00000000 valid=1 pc=fffffffc",
                     to_imem, inst_valid, inst_pc);
        end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0 || to_imem !== RESET_PC) begin
                failures++;
                $display("FAIL midreset k=%0d got req=%b valid=%b to=%h want req=0 valid=0 to=%h",
                         k, imem_req, inst_valid, to_imem, RESET_PC);
            end
            tick();
        end
        rst = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || to_imem !== RESET_PC) begin
            failures++;
            $display("FAIL midreset_release got valid=%b req=%b to=%h want valid=0 req=1 to=%h",
                     inst_valid, imem_req, to_imem, RESET_PC);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            imem_ack       = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom();
            rst            = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0)
                fr_imem = {1'b1, 6'($urandom()), 5'($urandom()), 5'($urandom()), 3'b001,
                           4'($urandom()), 1'($urandom()), 7'b1100011};
            else
                fr_imem = $urandom();
            @(negedge clk);
            checks++;
            if (obs_bus() !== exp_bus()) begin
                failures++;
                $display("FAIL random_bus k=%0d got=%h want=%h", k, obs_bus(), exp_bus());
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_predict();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the prefetch buffer entry count (legal values 2..4).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL provide these ports (name, direction, width, meaning):
  clk             in   1   rising-edge clock
  rst             in   1   synchronous, active-high reset
  to_imem         out  32  fetch address, word-aligned
  imem_req        out  1   fetch request valid
  imem_ack        in   1   imem accepted the request; fr_imem valid this cycle
  fr_imem         in   32  instruction word
  redirect_valid  in   1   core branch/jump resolved taken
  redirect_pc     in   32  redirect target
  inst_valid      out  1   buffer head valid
  inst_ready      in   1   core consumes head
  inst            out  32  head instruction
  inst_pc         out  32  head instruction PC
  inst_pred_taken out  1   head was predicted taken (0 when macro absent)

Function
REQ-005 SHALL assert imem_req iff buffer count < FIFO_DEPTH and not rst; to_imem = current fetch PC.
REQ-006 SHALL hold to_imem stable while imem_req=1 and imem_ack=0, unless redirect_valid=1.
REQ-007 On imem_req & imem_ack, SHALL push {fetch PC, fr_imem, pred} into the buffer and update the fetch PC in the same edge (default PC+4, modulo 2^32 wrap).
REQ-008 inst/inst_pc/inst_pred_taken SHALL reflect the buffer head combinationally; pop on inst_valid & inst_ready.
REQ-009 Minimum latency SHALL be one cycle: a word acked in cycle N is at the head with inst_valid=1 in cycle N+1 when the buffer was empty.
REQ-010 Push and pop in the same cycle SHALL leave the count unchanged; no push is possible when full (per REQ-005).
REQ-011 redirect_valid SHALL take priority over everything: the buffer is flushed, any ack in that cycle is discarded, the fetch PC becomes {redirect_pc[31:2],2'b00}, and inst_valid=0 in the next cycle.
REQ-012 A pop coinciding with a redirect SHALL count as consumed; no replay.
REQ-013 Buffer pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-014 While rst=1: fetch PC=RESET_PC, buffer empty, imem_req=0, inst_valid=0, inst_pred_taken=0, inst=0, inst_pc=0.
REQ-015 rst SHALL override redirect_valid and imem_ack; the first request (to_imem=RESET_PC) occurs in the cycle after rst falls.

Configuration
REQ-016 With FETCH_BRANCH_PREDICT_EN defined: on push of an opcode 7'b1100011 word with negative B-immediate, the next fetch PC SHALL be PC+sext(imm) and pred=1; forward or non-branch words yield PC+4 and pred=0.
REQ-017 Without FETCH_BRANCH_PREDICT_EN: the next fetch PC SHALL always be PC+4, inst_pred_taken is tied to 0, and no immediate decode logic is present.

Structure
REQ-018 Package fetch_pkg SHALL hold OPC_BRANCH=7'b1100011, INSN_NOP=32'h0000_0013, the default RESET_PC, and the buffer entry struct {pc, insn, pred}.
REQ-019 The buffer SHALL be a sub-module fetch_fifo (parameterised depth, flush input, registered pointers and count); the PC and prediction logic SHALL live in fetch_unit.

Verification
REQ-020 Release reset with imem_ack=1 constant and inst_ready=1 -> to_imem sequence 0x0, 0x4, 0x8; inst_pc follows one cycle later.
REQ-021 inst_ready=0 with imem_ack=1 -> after two acks, imem_req=0 and to_imem holds 0x8; raising inst_ready resumes requests the next cycle.
REQ-022 redirect_valid=1 with redirect_pc=0x103 while the buffer is full and an ack is pending -> next cycle inst_valid=0, to_imem=0x100, and the discarded word never appears.
REQ-023 Macro on, PC=0x40, fr_imem=0xFE311CE3 (BNE imm -8) -> next to_imem=0x38 and inst_pred_taken=1; fr_imem=0x00311263 (imm +4) -> next to_imem=0x44, pred=0.
REQ-024 Macro off, same 0xFE311CE3 stimulus -> next to_imem=0x44, inst_pred_taken=0.
REQ-025 Fetch PC 0xFFFF_FFFC acked -> next to_imem=0x0000_0000; rst asserted mid-stream -> next cycle buffer empty, imem_req=0.
